// File: rtl/mlp_accuracy_monitor.sv
// mlp_accuracy_monitor: scores MLP predictions against a golden label memory
// and reports overall accuracy in basis points at the end of a run.
module mlp_accuracy_monitor #(
  parameter int NUM_CLASSES    = 10,
  parameter int CLASS_W        = 4,
  parameter int NUM_TEST_CASES = 750,
  parameter int CASE_W         = 10,
  parameter int ACC_W          = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               restart,
  input  logic               pred_valid,
  input  logic [CLASS_W-1:0] pred_label,
  output logic [CASE_W-1:0]  label_addr,
  input  logic [CLASS_W-1:0] label_data,
  output logic               busy,
  output logic [CASE_W-1:0]  case_count,
  output logic [CASE_W-1:0]  wrong_count,
  input  logic [CLASS_W-1:0] class_sel,
  output logic [CASE_W-1:0]  class_hits,
  output logic [CASE_W-1:0]  class_total,
  output logic [ACC_W-1:0]   accuracy_bp,
  output logic               done,
  output logic               overrun,
  output logic               bad_label
);

  localparam int NW  = CASE_W + 14;
  localparam int DCW = $clog2(NW);

  localparam logic [CLASS_W:0]  NCL   = (CLASS_W+1)'(NUM_CLASSES);
  localparam logic [CASE_W-1:0] NTC   = CASE_W'(NUM_TEST_CASES);
  localparam logic [DCW-1:0]    DLAST = DCW'(NW - 1);
  localparam logic [NW-1:0]     SCALE = NW'(10000);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    COMPARE,
    DIVIDE,
    DONE
  } state_t;

  state_t state, nxt;

  logic [CLASS_W-1:0] pred_q;
  logic [CASE_W-1:0]  addr_q;
  logic [CASE_W-1:0]  cases_q;
  logic [CASE_W-1:0]  wrong_q;
  logic [CASE_W-1:0]  hits_q [NUM_CLASSES];
  logic [CASE_W-1:0]  tot_q  [NUM_CLASSES];
  logic [CASE_W-1:0]  rem_q;
  logic [NW-1:0]      quo_q;
  logic [DCW-1:0]     dcnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovr_q;
  logic               bad_q;

  logic               clr;
  logic               p_bad;
  logic               t_bad;
  logic               hit;
  logic [CASE_W-1:0]  cases_nx;
  logic [CASE_W-1:0]  wrong_nx;
  logic [NW-1:0]      numer;
  logic [CASE_W:0]    trial;
  logic               qbit;
  logic [CASE_W-1:0]  rem_nx;
  logic [NW-1:0]      quo_nx;

  // Compare results and one restoring-divide step
  always_comb begin
    clr      = restart && (state == IDLE || state == DONE);
    p_bad    = {1'b0, pred_q} >= NCL;
    t_bad    = {1'b0, label_data} >= NCL;
    hit      = !p_bad && (pred_q == label_data);
    cases_nx = cases_q + CASE_W'(1);
    wrong_nx = hit ? wrong_q : wrong_q + CASE_W'(1);
    numer    = NW'(NTC - wrong_nx) * SCALE;
    trial    = {rem_q, quo_q[NW-1]};
    qbit     = trial >= {1'b0, NTC};
    rem_nx   = qbit ? CASE_W'(trial - {1'b0, NTC})
                    : trial[CASE_W-1:0];
    quo_nx   = {quo_q[NW-2:0], qbit};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else if (clk_en)
      state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (restart)
          nxt = IDLE;
        else if (pred_valid)
          nxt = FETCH;
      end
      FETCH:
        nxt = COMPARE;
      COMPARE:
        nxt = (cases_nx == NTC) ? DIVIDE : IDLE;
      DIVIDE:
        if (dcnt_q == DLAST)
          nxt = DONE;
      DONE:
        if (restart)
          nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  // Counters, flags and divider datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_q  <= '0;
      addr_q  <= '0;
      cases_q <= '0;
      wrong_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dcnt_q  <= '0;
      acc_q   <= '0;
      ovr_q   <= 1'b0;
      bad_q   <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        hits_q[i] <= '0;
        tot_q[i]  <= '0;
      end
    end else if (clk_en) begin
      if (clr) begin
        addr_q  <= '0;
        cases_q <= '0;
        wrong_q <= '0;
        rem_q   <= '0;
        quo_q   <= '0;
        dcnt_q  <= '0;
        acc_q   <= '0;
        ovr_q   <= 1'b0;
        bad_q   <= 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
          hits_q[i] <= '0;
          tot_q[i]  <= '0;
        end
      end else begin
        if (pred_valid && state != IDLE)
          ovr_q <= 1'b1;
        case (state)
          IDLE: begin
            if (pred_valid) begin
              pred_q <= pred_label;
              addr_q <= cases_q;
            end
          end
          COMPARE: begin
            cases_q <= cases_nx;
            wrong_q <= wrong_nx;
            if (p_bad || t_bad)
              bad_q <= 1'b1;
            if (!t_bad) begin
              tot_q[label_data] <= tot_q[label_data] + CASE_W'(1);
              if (hit)
                hits_q[label_data] <= hits_q[label_data] + CASE_W'(1);
            end
            if (cases_nx == NTC) begin
              rem_q  <= '0;
              quo_q  <= numer;
              dcnt_q <= '0;
            end
          end
          DIVIDE: begin
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
            dcnt_q <= dcnt_q + DCW'(1);
            if (dcnt_q == DLAST)
              acc_q <= quo_nx[ACC_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Per-class readout; out-of-range classes read as zero
  always_comb begin
    class_hits  = '0;
    class_total = '0;
    if ({1'b0, class_sel} < NCL) begin
      class_hits  = hits_q[class_sel];
      class_total = tot_q[class_sel];
    end
  end

  assign label_addr  = addr_q;
  assign busy        = (state != IDLE);
  assign case_count  = cases_q;
  assign wrong_count = wrong_q;
  assign accuracy_bp = acc_q;
  assign done        = (state == DONE);
  assign overrun     = ovr_q;
  assign bad_label   = bad_q;

endmodule
